// File: rtl/mastermind_pkg.sv
// Shared types and constants for the Mastermind secret-code generator.
// Holds the code geometry (pegs, colours, digit width), the digit and
// index types, the generator state encoding and the colour range check.
package mastermind_pkg;

  localparam int NUM_PEGS   = 4;
  localparam int NUM_COLORS = 6;
  localparam int COLOR_W    = 3;
  localparam int IDX_W      = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } gen_state_t;

  // One extra bit on the compare so that NUM_COLORS == 2**COLOR_W
  // (every pattern legal) does not wrap to zero.
  function automatic logic color_legal(input color_t c);
    return {1'b0, c} < (COLOR_W+1)'(NUM_COLORS);
  endfunction

endpackage

// File: rtl/code_dup_check.sv
// Repeat detector for the code generator.
// Compares a candidate colour against the digits already written, looking
// only at slots 0..idx_i-1 (slots at or above idx_i hold stale/zero data).
// Ports:
//   digits_i  digit registers of the code being built
//   cand_i    candidate colour drawn this cycle
//   idx_i     number of digits already accepted
//   dup_o     1 when cand_i equals one of the accepted digits
module code_dup_check
  import mastermind_pkg::*;
(
  input  color_t [NUM_PEGS-1:0] digits_i,
  input  color_t                cand_i,
  input  idx_t                  idx_i,
  output logic                  dup_o
);

  logic [NUM_PEGS-1:0] hit;

  for (genvar g = 0; g < NUM_PEGS; g++) begin : g_slot
    assign hit[g] = (IDX_W'(g) < idx_i) && (digits_i[g] == cand_i);
  end

  assign dup_o = |hit;

endmodule

// File: rtl/code_gen_ctrl.sv
// Secret-code generator controller.
// Free-runs an external LFSR while idle, then on start draws LFSR values by
// rejection sampling until NUM_PEGS legal digits are collected or the draw
// budget runs out. Also clears the LFSR out of its all-ones lock-up state.
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   start_i       request a new code (level, sampled each edge)
//   lfsr_q_i      current LFSR state
//   lfsr_step_o   LFSR advance enable (combinational)
//   lfsr_clr_o    LFSR synchronous clear on lock-up (combinational)
//   busy_o        drawing in progress
//   code_valid_o  code_o holds a complete legal code
//   err_o         draw budget exhausted, code_o holds a partial fill
//   code_o        digit i at [i*COLOR_W +: COLOR_W]
//   draws_o       draws consumed by the last/current request
module code_gen_ctrl
  import mastermind_pkg::*;
#(
  parameter int LFSR_W       = 8,
  parameter int ALLOW_REPEAT = 1,
  parameter int MAX_DRAWS    = 64,
  localparam int DRAW_W      = $clog2(MAX_DRAWS + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [LFSR_W-1:0]           lfsr_q_i,
  output logic                        lfsr_step_o,
  output logic                        lfsr_clr_o,
  output logic                        busy_o,
  output logic                        code_valid_o,
  output logic                        err_o,
  output logic [NUM_PEGS*COLOR_W-1:0] code_o,
  output logic [DRAW_W-1:0]           draws_o
);

  gen_state_t            state_q, state_d;
  color_t [NUM_PEGS-1:0] digits_q, digits_d;
  idx_t                  idx_q, idx_d;
  logic [DRAW_W-1:0]     draws_q, draws_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic   lock, draw, dup, accept, last_acc, budget_hit, restart;
  color_t cand;

  assign lock = &lfsr_q_i;
  assign cand = lfsr_q_i[COLOR_W-1:0];

  code_dup_check u_dup (
    .digits_i (digits_q),
    .cand_i   (cand),
    .idx_i    (idx_q),
    .dup_o    (dup)
  );

  // A lock-up cycle is not a draw: the LFSR value is meaningless there.
  assign draw       = (state_q == SAMPLE) && !lock;
  assign accept     = draw && color_legal(cand) && ((ALLOW_REPEAT != 0) || !dup);
  assign last_acc   = accept && (idx_q == IDX_W'(NUM_PEGS - 1));
  // This draw is the one that brings the count to MAX_DRAWS.
  assign budget_hit = draw && (draws_q == DRAW_W'(MAX_DRAWS - 1));
  assign restart    = ((state_q == IDLE) || (state_q == DONE)) && start_i;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SAMPLE;
      SAMPLE:  if (last_acc || budget_hit) state_d = DONE;
      DONE:    if (start_i) state_d = SAMPLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // LFSR is frozen in DONE so the drawn code's successor state is kept.
  always_comb begin
    lfsr_clr_o  = lock;
    lfsr_step_o = 1'b0;
    case (state_q)
      IDLE, SAMPLE: lfsr_step_o = !lock;
      default:      lfsr_step_o = 1'b0;
    endcase
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    digits_d = digits_q;
    idx_d    = idx_q;
    draws_d  = draws_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    err_d    = err_q;
    if (restart) begin
      digits_d = '0;
      idx_d    = '0;
      draws_d  = '0;
      busy_d   = 1'b1;
      valid_d  = 1'b0;
      err_d    = 1'b0;
    end else if (draw) begin
      if (draws_q != DRAW_W'(MAX_DRAWS)) draws_d = draws_q + 1'b1;
      if (accept) begin
        digits_d[idx_q] = cand;
        if (!last_acc) idx_d = idx_q + 1'b1;
      end
      // Completion wins when the final digit lands on the last budgeted draw.
      if (last_acc) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end else if (budget_hit) begin
        busy_d = 1'b0;
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digits_q <= '0;
      idx_q    <= '0;
      draws_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      idx_q    <= idx_d;
      draws_q  <= draws_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign busy_o       = busy_q;
  assign code_valid_o = valid_q;
  assign err_o        = err_q;
  assign code_o       = digits_q;
  assign draws_o      = draws_q;

endmodule

// File: tb/tb_code_gen_ctrl.sv
// Bench for code_gen_ctrl: two instances (repeats allowed / rejected) share
// the same start and LFSR stimulus and are checked against a per-request
// reference computed from the draw rules.
module tb_code_gen_ctrl;

  localparam int MAXD = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  lfsr = 8'h00;

  logic        step_r, clr_r, busy_r, val_r, err_r;
  logic [11:0] code_r;
  logic [6:0]  draws_r;
  logic        step_n, clr_n, busy_n, val_n, err_n;
  logic [11:0] code_n;
  logic [6:0]  draws_n;

  always #5 clk = ~clk;

  code_gen_ctrl #(.LFSR_W(8), .ALLOW_REPEAT(1), .MAX_DRAWS(MAXD)) dut_r (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .lfsr_q_i(lfsr),
    .lfsr_step_o(step_r), .lfsr_clr_o(clr_r), .busy_o(busy_r),
    .code_valid_o(val_r), .err_o(err_r), .code_o(code_r), .draws_o(draws_r)
  );

  code_gen_ctrl #(.LFSR_W(8), .ALLOW_REPEAT(0), .MAX_DRAWS(MAXD)) dut_n (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .lfsr_q_i(lfsr),
    .lfsr_step_o(step_n), .lfsr_clr_o(clr_n), .busy_o(busy_n),
    .code_valid_o(val_n), .err_o(err_n), .code_o(code_n), .draws_o(draws_n)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] stim [256];
  int         slen;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== 32'(exp)) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the LFSR values the request will see; skip lock-ups,
  // count draws, keep legal (and, if required, fresh) colours.
  // n = number of SAMPLE edges until the request finishes.
  function automatic void ref_run(input bit rep, output int n, output int code,
                                  output int draws, output bit err);
    int got[$];
    int c;
    bit seen;
    n = slen; code = 0; draws = 0; err = 0;
    for (int i = 0; i < slen; i++) begin
      if (stim[i] == 8'hFF) continue;
      draws++;
      c = stim[i] % 8;
      seen = 0;
      foreach (got[k]) if (got[k] == c) seen = 1;
      if (c < 6 && (rep || !seen)) got.push_back(c);
      if (got.size() == 4) begin n = i + 1; break; end
      if (draws == MAXD) begin err = 1; n = i + 1; break; end
    end
    foreach (got[k]) code += got[k] * (1 << (3 * k));
  endfunction

  // Called just after a rising edge; leaves just after a rising edge.
  task automatic run_req(input bit pulses);
    int nr, nn, cr, cn, dr, dn, nmax, nmin;
    bit er, en;
    ref_run(1'b1, nr, cr, dr, er);
    ref_run(1'b0, nn, cn, dn, en);
    nmax = (nr > nn) ? nr : nn;
    nmin = (nr < nn) ? nr : nn;
    start = 1'b1; lfsr = 8'h10;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy_r", busy_r, 1);  chk("start_busy_n", busy_n, 1);
    chk("start_val_r", val_r, 0);    chk("start_err_r", err_r, 0);
    chk("start_err_n", err_n, 0);    chk("start_draws_r", draws_r, 0);
    chk("start_draws_n", draws_n, 0); chk("start_code_r", code_r, 0);
    for (int i = 0; i < nmax; i++) begin
      lfsr  = stim[i];
      start = pulses && (i < nmin) && ($urandom_range(0, 3) == 0);
      #1;
      chk("clr_r", clr_r, stim[i] == 8'hFF);
      chk("clr_n", clr_n, stim[i] == 8'hFF);
      chk("step_r", step_r, (i < nr) && stim[i] != 8'hFF);
      chk("step_n", step_n, (i < nn) && stim[i] != 8'hFF);
      @(posedge clk); #1;
      chk("busy_r", busy_r, i + 1 < nr);
      chk("busy_n", busy_n, i + 1 < nn);
      chk("valid_r", val_r, (i + 1 >= nr) && !er);
      chk("valid_n", val_n, (i + 1 >= nn) && !en);
      chk("err_r", err_r, (i + 1 >= nr) && er);
      chk("err_n", err_n, (i + 1 >= nn) && en);
    end
    start = 1'b0;
    chk("code_r", code_r, cr);   chk("code_n", code_n, cn);
    chk("draws_r", draws_r, dr); chk("draws_n", draws_n, dn);
  endtask

  task automatic load(input logic [7:0] v [$]);
    slen = v.size();
    foreach (v[k]) stim[k] = v[k];
  endtask

  initial begin
    logic [7:0] v [$];
    int mode;
    logic [7:0] x;

    // Reset state
    #3;
    chk("rst_busy", busy_r, 0); chk("rst_val", val_r, 0); chk("rst_err", err_n, 0);
    chk("rst_code", code_r, 0); chk("rst_draws", draws_n, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    lfsr = 8'h00; #1;
    chk("idle_step", step_r, 1); chk("idle_clr", clr_r, 0);
    lfsr = 8'hFF; #1;
    chk("idle_lock_step", step_n, 0); chk("idle_lock_clr", clr_n, 1);
    @(posedge clk); #1;

    // Directed: all-accept run, 4-edge latency
    v = '{8'h01, 8'h02, 8'h03, 8'h04}; load(v); run_req(1'b0);
    chk("t2_code", code_r, 12'h8D1); chk("t2_draws", draws_r, 4); chk("t2_valid", val_r, 1);
    lfsr = 8'h05; #1;
    chk("t2_done_step", step_r, 0); chk("t2_done_step_n", step_n, 0);
    @(posedge clk); #1;
    chk("t2_hold_code", code_r, 12'h8D1);

    // Out-of-range colours rejected
    v = '{8'h07, 8'h06, 8'h01, 8'h02, 8'h03, 8'h05}; load(v); run_req(1'b0);
    chk("t3_code", code_r, 12'hAD1); chk("t3_draws", draws_r, 6);

    // Repeat rejected only by the no-repeat instance
    v = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04}; load(v); run_req(1'b0);
    chk("t4_code_n", code_n, 12'h8D1); chk("t4_draws_n", draws_n, 5);
    chk("t4_code_r", code_r, 12'h689); chk("t4_draws_r", draws_r, 4);

    // Lock-up cycles are not draws
    v = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04}; load(v); run_req(1'b0);
    chk("t5_draws", draws_r, 4); chk("t5_code", code_n, 12'h8D1);

    // Budget exhaustion with start pulses while busy
    v.delete(); for (int k = 0; k < MAXD; k++) v.push_back(8'h07);
    load(v); run_req(1'b1);
    chk("t6_err", err_r, 1); chk("t6_valid", val_r, 0); chk("t6_draws", draws_r, MAXD);

    // Reset mid-SAMPLE
    v = '{8'h01, 8'h02, 8'h03, 8'h04}; load(v);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    lfsr = 8'h01; @(posedge clk); #1;
    lfsr = 8'h02; #2; rst_n = 1'b0; #1;
    chk("mid_rst_busy", busy_r, 0); chk("mid_rst_draws", draws_r, 0);
    chk("mid_rst_code", code_r, 0); chk("mid_rst_err", err_r, 0);
    chk("mid_rst_val", val_n, 0);
    #2; rst_n = 1'b1;
    @(posedge clk); #1; lfsr = 8'h05; #1;
    chk("post_rst_step", step_r, 1); chk("post_rst_busy", busy_r, 0);
    @(posedge clk); #1;

    // Randomized requests
    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(0, 3);
      for (int k = 0; k < 200; k++) begin
        case (mode)
          0: x = 8'($urandom);
          1: x = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                               : {5'($urandom), 3'($urandom_range(6, 7))};
          2: x = {5'($urandom), 3'($urandom_range(1, 2))};
          default: x = {5'($urandom), 3'($urandom_range(0, 5))};
        endcase
        if ($urandom_range(0, 15) == 0) x = 8'hFF;
        if (k >= 100 && x == 8'hFF) x = 8'h07;
        stim[k] = x;
      end
      slen = 200;
      run_req(1'b1);
      if ($urandom_range(0, 1) == 1) begin
        lfsr = 8'($urandom); @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
